instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the instruction-memory word-address width; DEPTH = 2**ADDR_W words.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-low (reset=0 resets).
REQ-004 SHALL have port start, input, 1, a one-cycle request to begin a program load.
REQ-005 SHALL have port in_valid, input, 1, and port in_ready, output, 1, forming the instruction-field handshake.
REQ-006 SHALL have port in_last, input, 1, marking the final instruction of the program.
REQ-007 SHALL have port fmt, input, 3, with 0=R, 1=I-ALU, 2=LW, 3=SW, 4=BEQ, 5=JAL, 6=JALR, 7=reserved.
REQ-008 SHALL have ports rd, rs1 and rs2, input, 5 each, plus funct3, input, 3, and funct7, input, 7.
REQ-009 SHALL have port imm, input, 32, a signed byte-offset immediate.
REQ-010 SHALL have ports imem_we, output, 1; imem_waddr, output, ADDR_W; and imem_wdata, output, 32.
REQ-011 SHALL have ports cpu_hold, output, 1 (keeps the processor in reset); done, output, 1; err, output, 1 (sticky); and count, output, ADDR_W+1.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD and DONE.
REQ-013 SHALL move IDLE->LOAD on start, clearing count and err; in DONE, start SHALL also restart to LOAD; in LOAD, start SHALL be ignored.
REQ-014 SHALL drive in_ready=1 only in LOAD, while the last instruction is not yet accepted and count<DEPTH.
REQ-015 SHALL accept fields on in_valid&&in_ready; with acceptance in cycle N, imem_we=1 in cycle N+1 with imem_waddr=count[ADDR_W-1:0] and imem_wdata=encoded word, and count SHALL increment at the end of cycle N+1.
REQ-016 SHALL sustain back-to-back acceptance, one word per cycle, with no bubbles.
REQ-017 SHALL encode R as funct7|rs2|rs1|funct3|rd|0110011.
REQ-018 SHALL encode I-ALU as imm[11:0]|rs1|funct3|rd|0010011.
REQ-019 SHALL encode LW as imm[11:0]|rs1|010|rd|0000011, forcing funct3=010 regardless of the funct3 input.
REQ-020 SHALL encode SW as imm[11:5]|rs2|rs1|010|imm[4:0]|0100011.
REQ-021 SHALL encode BEQ as imm[12]|imm[10:5]|rs2|rs1|000|imm[4:1]|imm[11]|1100011.
REQ-022 SHALL encode JAL as imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111.
REQ-023 SHALL encode JALR as imm[11:0]|rs1|000|rd|1100111.
REQ-024 SHALL, for fmt=7, write NOP 0x00000013 and set err.
REQ-025 SHALL set err for an out-of-range imm: I/LW/SW/JALR outside 12-bit signed; BEQ outside 13-bit signed or odd; JAL outside 21-bit signed or odd. The truncated encoding SHALL still be written.
REQ-026 SHALL transition LOAD->DONE in the cycle after the write of an instruction accepted with in_last=1.
REQ-027 SHALL treat the DEPTH-th accepted word as last (set err if its in_last=0); no write SHALL wrap to address 0.
REQ-028 SHALL drive cpu_hold=1 in IDLE and LOAD, and 0 in DONE; done=1 only in DONE.
REQ-029 SHALL keep imem_we=0 in IDLE and DONE, and keep the outputs stable while in_valid=0.

Reset
REQ-030 SHALL, on reset=0 at any time (including mid-load), immediately force IDLE: in_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, count=0, err=0, done=0, cpu_hold=1.
REQ-031 SHALL discard a pending (accepted, unwritten) word on reset.
REQ-032 SHALL require start after reset release before any write.

Verification
REQ-033 SHALL pass: start; addi x1,x0,5 (fmt=1, funct3=0, imm=5) -> imem_wdata=0x00500093 at address 0 one cycle after acceptance.
REQ-034 SHALL pass: back-to-back add x3,x1,x2 / sw x2,8(x1) / lw x5,8(x1)+last -> 0x002081B3, 0x0020A423, 0x0080A283 at addresses 0,1,2 on consecutive cycles, then done=1, cpu_hold=0, count=3.
REQ-035 SHALL pass: beq x1,x2,imm=-8 -> 0xFE208CE3; jal x1,imm=16 -> 0x010000EF.
REQ-036 SHALL pass: fmt=7, or I-ALU with imm=4096 -> NOP or the truncated word written, err=1, and the load continues.
REQ-037 SHALL pass: with ADDR_W=2, five instructions offered without last -> four writes (addresses 0-3), in_ready=0 thereafter, err=1, DONE.
REQ-038 SHALL pass: reset=0 in the cycle after an acceptance -> no imem_we, IDLE outputs per REQ-030; a subsequent start reloads from address 0.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder
// Streams RV32I instruction fields in, encodes each into a 32-bit word and
// writes it into instruction memory while holding the processor in reset.
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous, active-low
//   start        one-cycle request to begin (or restart) a program load
//   in_valid/in_ready/in_last  field handshake; in_last marks final instr
//   fmt,rd,rs1,rs2,funct3,funct7,imm  instruction fields
//   imem_we/imem_waddr/imem_wdata    instruction-memory write port
//   cpu_hold     1 keeps the processor in reset (IDLE, LOAD)
//   done         1 in DONE
//   err          sticky error (reserved fmt, bad immediate, overflow)
//   count        number of words written in this load
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        fmt,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] DEPTH     = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0] DEPTH_M1  = (ADDR_W+1)'(2**ADDR_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_q, err_d;
  logic                last_q, last_d;     // final word has been accepted
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;

  logic [31:0]         enc_word;
  logic                enc_bad;
  logic [ADDR_W:0]     accepted_total;
  logic                accept;
  logic                fits12, fits13, fits21;

  // Words accepted so far: written ones plus the one waiting to be written.
  assign accepted_total = count_q + {{ADDR_W{1'b0}}, we_q};
  assign in_ready = (state_q == LOAD) && !last_q && (accepted_total < DEPTH);
  assign accept   = in_valid && in_ready;

  assign fits12 = ($signed(imm) >= -32'sd2048)    && ($signed(imm) <= 32'sd2047);
  assign fits13 = ($signed(imm) >= -32'sd4096)    && ($signed(imm) <= 32'sd4095);
  assign fits21 = ($signed(imm) >= -32'sd1048576) && ($signed(imm) <= 32'sd1048575);

  always_comb begin
    enc_word = 32'h0000_0013;
    enc_bad  = 1'b0;
    case (fmt)
      3'd0: enc_word = {funct7, rs2, rs1, funct3, rd, 7'b0110011};
      3'd1: begin
        enc_word = {imm[11:0], rs1, funct3, rd, 7'b0010011};
        enc_bad  = !fits12;
      end
      3'd2: begin
        enc_word = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
        enc_bad  = !fits12;
      end
      3'd3: begin
        enc_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
        enc_bad  = !fits12;
      end
      3'd4: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
        enc_bad  = !fits13 || imm[0];
      end
      3'd5: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
        enc_bad  = !fits21 || imm[0];
      end
      3'd6: begin
        enc_word = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
        enc_bad  = !fits12;
      end
      default: begin
        enc_word = 32'h0000_0013;
        enc_bad  = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    last_d  = last_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          count_d = '0;
          err_d   = 1'b0;
          last_d  = 1'b0;
        end
      end
      LOAD: begin
        if (we_q) begin
          count_d = count_q + 1'b1;
          // last_q with a write in flight means this is the final word
          if (last_q) state_d = DONE;
        end
        if (accept) begin
          we_d    = 1'b1;
          waddr_d = accepted_total[ADDR_W-1:0];
          wdata_d = enc_word;
          // The DEPTH-th word closes the load even without in_last.
          last_d  = in_last || (accepted_total == DEPTH_M1);
          err_d   = err_q || enc_bad || ((accepted_total == DEPTH_M1) && !in_last);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      last_q  <= last_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign err        = err_q;
  assign done       = (state_q == DONE);
  assign cpu_hold   = (state_q != DONE);

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_last = 1'b0;
  logic [2:0]    fmt = '0;
  logic [4:0]    rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]    funct3 = '0;
  logic [6:0]    funct7 = '0;
  logic [31:0]   imm = '0;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold, done, err;
  logic [AW:0]   count;

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          wcyc;
  } exp_t;

  exp_t          exp_q[$];
  logic [31:0]   wlog[$];
  int            m_acc = 0;
  bit            m_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference encoder: field placement by shift-and-mask arithmetic.
  function automatic logic [31:0] model_enc(input int f, input int rdv, input int r1,
                                            input int r2, input int f3, input int f7,
                                            input int iv, output bit bad);
    logic [31:0] u;
    u   = iv;
    bad = 0;
    case (f)
      0: model_enc = (32'(f7) << 25) | (32'(r2) << 20) | (32'(r1) << 15) |
                     (32'(f3) << 12) | (32'(rdv) << 7) | 32'h33;
      1: begin
        model_enc = ((u & 32'hfff) << 20) | (32'(r1) << 15) | (32'(f3) << 12) |
                    (32'(rdv) << 7) | 32'h13;
        bad = (iv < -2048) || (iv > 2047);
      end
      2: begin
        model_enc = ((u & 32'hfff) << 20) | (32'(r1) << 15) | (32'd2 << 12) |
                    (32'(rdv) << 7) | 32'h03;
        bad = (iv < -2048) || (iv > 2047);
      end
      3: begin
        model_enc = (((u >> 5) & 32'h7f) << 25) | (32'(r2) << 20) | (32'(r1) << 15) |
                    (32'd2 << 12) | ((u & 32'h1f) << 7) | 32'h23;
        bad = (iv < -2048) || (iv > 2047);
      end
      4: begin
        model_enc = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3f) << 25) |
                    (32'(r2) << 20) | (32'(r1) << 15) | (((u >> 1) & 32'hf) << 8) |
                    (((u >> 11) & 1) << 7) | 32'h63;
        bad = (iv < -4096) || (iv > 4095) || (iv % 2 != 0);
      end
      5: begin
        model_enc = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3ff) << 21) |
                    (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hff) << 12) |
                    (32'(rdv) << 7) | 32'h6f;
        bad = (iv < -1048576) || (iv > 1048575) || (iv % 2 != 0);
      end
      6: begin
        model_enc = ((u & 32'hfff) << 20) | (32'(r1) << 15) | (32'(rdv) << 7) | 32'h67;
        bad = (iv < -2048) || (iv > 2047);
      end
      default: begin
        model_enc = 32'h13;
        bad = 1;
      end
    endcase
  endfunction

  // Monitor: every acceptance predicts one write in the following cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      if (exp_q.size() == 0) begin
        chk("spurious_we", imem_we, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("waddr", 64'(imem_waddr), 64'(e.addr));
        chk("wdata", 64'(imem_wdata), 64'(e.data));
        chk("wcycle", 64'(cyc), 64'(e.wcyc));
        wlog.push_back(imem_wdata);
      end
    end
    if (in_valid && in_ready) begin
      exp_t e;
      bit   b;
      e.addr = m_acc;
      e.data = model_enc(int'(fmt), int'(rd), int'(rs1), int'(rs2), int'(funct3),
                         int'(funct7), int'($signed(imm)), b);
      e.wcyc = cyc + 1;
      exp_q.push_back(e);
      m_acc++;
      if (b) m_err = 1;
      if (m_acc == DEPTH && !in_last) m_err = 1;
    end
  end

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    m_acc = 0;
    m_err = 0;
    exp_q.delete();
    wlog.delete();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic offer(input int f, input int rdv, input int r1, input int r2,
                       input int f3, input int f7, input logic [31:0] iv, input bit last);
    int n;
    fmt = 3'(f); rd = 5'(rdv); rs1 = 5'(r1); rs2 = 5'(r2);
    funct3 = 3'(f3); funct7 = 7'(f7); imm = iv;
    in_last = last;
    in_valid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 20) begin
        chk("offer_timeout", 64'(in_ready), 1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input int exp_count);
    int n;
    n = 0;
    while (n < 30) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    chk("done", 64'(done), 1);
    chk("cpu_hold", 64'(cpu_hold), 0);
    chk("in_ready_done", 64'(in_ready), 0);
    chk("count", 64'(count), 64'(exp_count));
    chk("err", 64'(err), 64'(m_err));
    chk("pending_empty", 64'(exp_q.size()), 0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 0);
    chk({tag, "_we"}, 64'(imem_we), 0);
    chk({tag, "_waddr"}, 64'(imem_waddr), 0);
    chk({tag, "_wdata"}, 64'(imem_wdata), 0);
    chk({tag, "_count"}, 64'(count), 0);
    chk({tag, "_err"}, 64'(err), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_hold"}, 64'(cpu_hold), 1);
  endtask

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 3))
      0:       rand_imm = $urandom;
      1:       rand_imm = $urandom_range(0, 8191) - 32'd4096;
      default: rand_imm = $urandom_range(0, 4095) - 32'd2048;
    endcase
  endfunction

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    reset = 1'b1;

    // No start yet: nothing may be accepted
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_start_ready", 64'(in_ready), 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;

    // addi x1,x0,5
    do_start();
    offer(1, 1, 0, 0, 0, 0, 32'd5, 1);
    wait_done(1);
    chk("addi_word", 64'(wlog.size() > 0 ? wlog[0] : 32'hx), 64'h00500093);

    // add / sw / lw back-to-back
    do_start();
    offer(0, 3, 1, 2, 0, 0, 32'd0, 0);
    offer(3, 0, 1, 2, 0, 0, 32'd8, 0);
    offer(2, 5, 1, 0, 7, 0, 32'd8, 1);
    wait_done(3);
    if (wlog.size() == 3) begin
      chk("add_word", 64'(wlog[0]), 64'h002081B3);
      chk("sw_word", 64'(wlog[1]), 64'h0020A423);
      chk("lw_word", 64'(wlog[2]), 64'h0080A283);
    end else chk("b2b_writes", 64'(wlog.size()), 3);

    // beq / jal
    do_start();
    offer(4, 0, 1, 2, 0, 0, -32'sd8, 0);
    offer(5, 1, 0, 0, 0, 0, 32'd16, 1);
    wait_done(2);
    if (wlog.size() == 2) begin
      chk("beq_word", 64'(wlog[0]), 64'hFE208CE3);
      chk("jal_word", 64'(wlog[1]), 64'h010000EF);
    end else chk("bj_writes", 64'(wlog.size()), 2);

    // reserved fmt and out-of-range immediate; load continues
    do_start();
    offer(7, 1, 2, 3, 1, 0, 32'd0, 0);
    offer(1, 1, 0, 0, 0, 0, 32'd4096, 0);
    offer(1, 2, 0, 0, 0, 0, 32'd1, 1);
    wait_done(3);
    chk("err_sticky", 64'(err), 1);
    if (wlog.size() == 3) begin
      chk("nop_word", 64'(wlog[0]), 64'h00000013);
      chk("trunc_word", 64'(wlog[1]), 64'h00000093);
    end else chk("err_writes", 64'(wlog.size()), 3);

    // Overflow: five offered without last, only four taken
    do_start();
    for (int i = 0; i < 4; i++) offer(1, i + 1, 0, 0, 0, 0, 32'(i), 0);
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("ovf_ready", 64'(in_ready), 0);
    end
    in_valid = 1'b0;
    wait_done(4);
    chk("ovf_err", 64'(err), 1);
    chk("ovf_writes", 64'(wlog.size()), 4);

    // Reset in the cycle after an acceptance
    do_start();
    offer(1, 1, 0, 0, 0, 0, 32'd5, 0);
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk_idle("midreset");
    @(negedge clk);
    chk("midreset_we", 64'(imem_we), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    do_start();
    offer(1, 7, 0, 0, 0, 0, 32'd3, 1);
    wait_done(1);

    // Randomized loads from DONE
    for (int t = 0; t < 12; t++) begin
      int n;
      n = $urandom_range(1, DEPTH);
      do_start();
      for (int i = 0; i < n; i++)
        offer($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 127),
              rand_imm(), i == n - 1);
      wait_done(n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
